// File: rtl/reg_writeback_unit_pkg.sv
// Shared widths, special register indices and the writeback entry format.
// No logic; constants and types only.
// Entry struct is sized by the package defaults; the top's widths must track these.
package reg_writeback_unit_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 4;
    localparam int WB_PC_IDX = 15;
    localparam int WB_LR_IDX = 14;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters driving BUSY, with a sticky misuse flag.
// Latency: counters update on the edge after issue/retire; BUSY is registered state.
// Backpressure: none; over/underflow saturates and raises sb_err instead of stalling.
module wb_scoreboard
    import reg_writeback_unit_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 flush,
    input  logic                 issue_vld,
    input  logic [ADDR_W-1:0]    issue_rd,
    input  logic                 retire_vld,
    input  logic [ADDR_W-1:0]    retire_rd,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 sb_err
);

    localparam int NREG = 2**ADDR_W;

    logic [1:0]      cnt_q [NREG];
    logic [1:0]      cnt_d [NREG];
    logic [NREG-1:0] inc_v;
    logic [NREG-1:0] dec_v;
    logic            err_set;

    assign inc_v = issue_vld  ? (NREG'(1) << issue_rd)  : '0;
    assign dec_v = retire_vld ? (NREG'(1) << retire_rd) : '0;

    // Next counter values: issue and retire of one register cancel; ends saturate and flag.
    always_comb begin
        err_set = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = 2'd0;
            end else if (inc_v[i] && !dec_v[i]) begin
                if (cnt_q[i] == 2'd3) err_set = 1'b1;
                else                  cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (dec_v[i] && !inc_v[i]) begin
                if (cnt_q[i] == 2'd0) err_set = 1'b1;
                else                  cnt_d[i] = cnt_q[i] - 2'd1;
            end
        end
    end

    // Counter state and sticky error; only reset clears sb_err.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= 2'd0;
            sb_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
            if (err_set) sb_err <= 1'b1;
        end
    end

    // A register is busy while any write to it is outstanding.
    always_comb begin
        for (int i = 0; i < NREG; i++) busy[i] = (cnt_q[i] != 2'd0);
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Merges ALU and load results into a small FIFO and drains one per cycle to the regfile port.
// Latency: accepted at edge k into an empty FIFO -> WE3 high after edge k+1.
// Backpressure: READY from registered count only (no same-cycle pop credit); MEM wins; FLUSH drops READY.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 2,
    parameter int PC_IDX = WB_PC_IDX
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 FLUSH,
    input  logic                 ALU_VALID,
    output logic                 ALU_READY,
    input  logic [ADDR_W-1:0]    ALU_RD,
    input  logic [DATA_W-1:0]    ALU_DATA,
    input  logic                 MEM_VALID,
    output logic                 MEM_READY,
    input  logic [ADDR_W-1:0]    MEM_RD,
    input  logic [DATA_W-1:0]    MEM_DATA,
    input  logic                 ISSUE_VALID,
    input  logic [ADDR_W-1:0]    ISSUE_RD,
    output logic [ADDR_W-1:0]    WA3,
    output logic [DATA_W-1:0]    WD3,
    output logic                 WE3,
    output logic                 PC_LOAD,
    output logic [2**ADDR_W-1:0] BUSY,
    output logic                 SB_ERR
);

    localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W     = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ROOM2 = CNT_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] PC_RD     = ADDR_W'(PC_IDX);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    wb_entry_t        fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] alu_ptr;
    logic             mem_acc;
    logic             alu_acc;
    logic             pop;
    wb_entry_t        head;

    // ALU needs two free slots when MEM is offering, since MEM takes the first one.
    assign MEM_READY = !FLUSH && (count_q < CNT_FULL);
    assign ALU_READY = !FLUSH && (MEM_VALID ? (count_q <= CNT_ROOM2) : (count_q < CNT_FULL));
    assign mem_acc   = MEM_VALID && MEM_READY;
    assign alu_acc   = ALU_VALID && ALU_READY;
    assign pop       = !FLUSH && (count_q != '0);
    assign head      = fifo_q[rd_ptr_q];
    assign alu_ptr   = mem_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    // Entry storage; MEM lands ahead of ALU when both are accepted.
    always_ff @(posedge CLK) begin
        if (mem_acc) fifo_q[wr_ptr_q] <= '{rd: MEM_RD, data: MEM_DATA};
        if (alu_acc) fifo_q[alu_ptr]  <= '{rd: ALU_RD, data: ALU_DATA};
    end

    // Pointers, occupancy and the registered regfile write port.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            WE3      <= 1'b0;
            PC_LOAD  <= 1'b0;
            WA3      <= '0;
            WD3      <= '0;
        end else if (FLUSH) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            WE3      <= 1'b0;
            PC_LOAD  <= 1'b0;
        end else begin
            if (alu_acc)      wr_ptr_q <= ptr_inc(alu_ptr);
            else if (mem_acc) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
                WA3      <= head.rd;
                WD3      <= head.data;
            end
            count_q <= count_q + CNT_W'(mem_acc) + CNT_W'(alu_acc) - CNT_W'(pop);
            WE3     <= pop;
            PC_LOAD <= pop && (head.rd == PC_RD);
        end
    end

    wb_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .CLK        (CLK),
        .nRST       (nRST),
        .flush      (FLUSH),
        .issue_vld  (ISSUE_VALID),
        .issue_rd   (ISSUE_RD),
        .retire_vld (WE3),
        .retire_rd  (WA3),
        .busy       (BUSY),
        .sb_err     (SB_ERR)
    );

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed + random stimulus against a queue/array reference model of the writeback unit.
// Model: expected writes are a FIFO queue, pending counts an int array per register.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_reg_writeback_unit;
    import reg_writeback_unit_pkg::*;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        nRST, FLUSH;
    logic        ALU_VALID, ALU_READY, MEM_VALID, MEM_READY, ISSUE_VALID;
    logic [3:0]  ALU_RD, MEM_RD, ISSUE_RD, WA3;
    logic [31:0] ALU_DATA, MEM_DATA, WD3;
    logic        WE3, PC_LOAD, SB_ERR;
    logic [15:0] BUSY;

    reg_writeback_unit #(.DATA_W(32), .ADDR_W(4), .DEPTH(DEPTH), .PC_IDX(15)) dut (
        .CLK(CLK), .nRST(nRST), .FLUSH(FLUSH),
        .ALU_VALID(ALU_VALID), .ALU_READY(ALU_READY), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
        .MEM_VALID(MEM_VALID), .MEM_READY(MEM_READY), .MEM_RD(MEM_RD), .MEM_DATA(MEM_DATA),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
        .WA3(WA3), .WD3(WD3), .WE3(WE3), .PC_LOAD(PC_LOAD), .BUSY(BUSY), .SB_ERR(SB_ERR)
    );

    always #5 CLK = ~CLK;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [3:0]  q_rd[$];
    logic [31:0] q_dat[$];
    logic [3:0]  iss_q[$];
    int          sb[16];
    logic        e_we, e_pc, e_err;
    logic [3:0]  e_wa;
    logic [31:0] e_wd;
    bit          mem_acc_m, alu_acc_m;
    int          n_acc, n_we, kk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_rd.delete(); q_dat.delete();
        for (int r = 0; r < 16; r++) sb[r] = 0;
        e_we = 0; e_pc = 0; e_err = 0; e_wa = '0; e_wd = '0;
    endtask

    function automatic logic [15:0] exp_busy();
        logic [15:0] b;
        for (int r = 0; r < 16; r++) b[r] = (sb[r] != 0);
        return b;
    endfunction

    task automatic drive_clear();
        FLUSH = 0; ALU_VALID = 0; MEM_VALID = 0; ISSUE_VALID = 0;
    endtask

    // One clock: check READY against free space, advance the model, check all outputs.
    task automatic cyc();
        int  n;
        bit  mrdy, ardy, macc, aacc;
        #1;
        n    = q_rd.size();
        mrdy = !FLUSH && (n < DEPTH);
        ardy = !FLUSH && (MEM_VALID ? (n <= DEPTH - 2) : (n < DEPTH));
        chk("mem_ready", MEM_READY, mrdy);
        chk("alu_ready", ALU_READY, ardy);
        macc = MEM_VALID && mrdy;
        aacc = ALU_VALID && ardy;
        @(posedge CLK);
        #1;
        if (FLUSH) begin
            q_rd.delete(); q_dat.delete();
            for (int r = 0; r < 16; r++) sb[r] = 0;
            e_we = 0; e_pc = 0;
        end else begin
            for (int r = 0; r < 16; r++) begin
                bit inc, dec;
                inc = ISSUE_VALID && (ISSUE_RD == 4'(r));
                dec = e_we && (e_wa == 4'(r));
                if (inc && !dec) begin
                    if (sb[r] == 3) e_err = 1; else sb[r]++;
                end else if (dec && !inc) begin
                    if (sb[r] == 0) e_err = 1; else sb[r]--;
                end
            end
            if (q_rd.size() > 0) begin
                e_we = 1; e_wa = q_rd.pop_front(); e_wd = q_dat.pop_front();
            end else begin
                e_we = 0;
            end
            e_pc = e_we && (e_wa == 4'd15);
            if (macc) begin q_rd.push_back(MEM_RD); q_dat.push_back(MEM_DATA); end
            if (aacc) begin q_rd.push_back(ALU_RD); q_dat.push_back(ALU_DATA); end
            n_acc += int'(macc) + int'(aacc);
        end
        if (WE3 === 1'b1) n_we++;
        chk("we3", WE3, e_we);
        chk("wa3", WA3, e_wa);
        chk("wd3", WD3, e_wd);
        chk("pc_load", PC_LOAD, e_pc);
        chk("busy", BUSY, exp_busy());
        chk("sb_err", SB_ERR, e_err);
        mem_acc_m = macc;
        alu_acc_m = aacc;
    endtask

    initial begin
        nRST = 0; drive_clear();
        ALU_RD = '0; ALU_DATA = '0; MEM_RD = '0; MEM_DATA = '0; ISSUE_RD = '0;
        model_reset();
        #1;
        chk("rst_we3", WE3, 0);      chk("rst_pc_load", PC_LOAD, 0);
        chk("rst_wa3", WA3, 0);      chk("rst_wd3", WD3, 0);
        chk("rst_busy", BUSY, 0);    chk("rst_sb_err", SB_ERR, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1;

        // Single ALU write, two-cycle latency.
        ALU_VALID = 1; ALU_RD = 4'd3; ALU_DATA = 32'h11; ISSUE_VALID = 1; ISSUE_RD = 4'd3;
        cyc();
        drive_clear();
        cyc();
        chk("t1_we", WE3, 1); chk("t1_wa", WA3, 3); chk("t1_wd", WD3, 32'h11); chk("t1_pc", PC_LOAD, 0);
        cyc();
        chk("t1_we_off", WE3, 0);

        // Simultaneous MEM + ALU: MEM drains first.
        ISSUE_VALID = 1; ISSUE_RD = 4'd5; cyc();
        ISSUE_RD = 4'd6; cyc();
        drive_clear();
        MEM_VALID = 1; MEM_RD = 4'd5; MEM_DATA = 32'hAA;
        ALU_VALID = 1; ALU_RD = 4'd6; ALU_DATA = 32'hBB;
        cyc();
        drive_clear();
        cyc(); chk("t2_first_wa", WA3, 5); chk("t2_first_wd", WD3, 32'hAA);
        cyc(); chk("t2_second_wa", WA3, 6); chk("t2_second_we", WE3, 1);
        cyc();

        // Both sources held valid: order and count preserved, FIFO never overfills.
        iss_q.delete(); n_acc = 0; n_we = 0; kk = 10;
        MEM_VALID = 1; MEM_RD = 4'd8; MEM_DATA = $urandom;
        ALU_VALID = 1; ALU_RD = 4'd9; ALU_DATA = $urandom;
        for (int i = 0; i < 20; i++) begin
            if (i >= 14) begin MEM_VALID = 0; ALU_VALID = 0; end
            if (iss_q.size() > 0) begin ISSUE_VALID = 1; ISSUE_RD = iss_q.pop_front(); end
            else ISSUE_VALID = 0;
            cyc();
            if (mem_acc_m) begin iss_q.push_back(MEM_RD); MEM_RD = 4'(8 + kk % 6); kk++; MEM_DATA = $urandom; end
            if (alu_acc_m) begin iss_q.push_back(ALU_RD); ALU_RD = 4'(8 + kk % 6); kk++; ALU_DATA = $urandom; end
        end
        chk("t3_write_count", n_we, n_acc);
        drive_clear();

        // Pending counter: two issues, two retires, then issue/retire on the same edge.
        ISSUE_VALID = 1; ISSUE_RD = 4'd4; cyc(); cyc();
        drive_clear();
        ALU_VALID = 1; ALU_RD = 4'd4; ALU_DATA = 32'h41; cyc();
        ALU_DATA = 32'h42; cyc();
        drive_clear();
        cyc(); chk("t4_busy_after_first_retire", BUSY[4], 1);
        cyc(); chk("t4_busy_after_second_retire", BUSY[4], 0);
        ISSUE_VALID = 1; ISSUE_RD = 4'd4; ALU_VALID = 1; ALU_RD = 4'd4; ALU_DATA = 32'h43; cyc();
        drive_clear(); cyc();
        ISSUE_VALID = 1; ISSUE_RD = 4'd4; cyc();
        chk("t4_busy_same_edge", BUSY[4], 1);
        drive_clear();

        // PC write.
        ISSUE_VALID = 1; ISSUE_RD = 4'd15; ALU_VALID = 1; ALU_RD = 4'd15; ALU_DATA = 32'h100; cyc();
        drive_clear(); cyc();
        chk("t5_we", WE3, 1); chk("t5_wa", WA3, 15); chk("t5_pc_load", PC_LOAD, 1);
        cyc(); chk("t5_pc_off", PC_LOAD, 0);

        // Flush with two queued entries, then deliberate scoreboard underflow/overflow.
        ISSUE_VALID = 1; ISSUE_RD = 4'd5; cyc();
        drive_clear();
        MEM_VALID = 1; MEM_RD = 4'd9; MEM_DATA = 32'h99;
        ALU_VALID = 1; ALU_RD = 4'd10; ALU_DATA = 32'h1010; cyc();
        FLUSH = 1;
        #1 chk("t6_busy_pre", BUSY, 16'h0030);
        cyc();
        chk("t6_we_flushed", WE3, 0); chk("t6_busy_flushed", BUSY, 0);
        drive_clear();
        #1;
        chk("t6_mem_ready", MEM_READY, 1); chk("t6_alu_ready", ALU_READY, 1);
        ALU_VALID = 1; ALU_RD = 4'd7; ALU_DATA = 32'h77; cyc();
        drive_clear(); cyc(); cyc();
        chk("t6_err_underflow", SB_ERR, 1);
        ISSUE_VALID = 1; ISSUE_RD = 4'd2; repeat (4) cyc();
        drive_clear(); repeat (3) cyc();
        chk("t6_err_sticky", SB_ERR, 1);

        // Random traffic with held-until-accepted sources, issues and rare flushes.
        for (int i = 0; i < 300; i++) begin
            if (!MEM_VALID && $urandom_range(1) == 1) begin
                MEM_VALID = 1; MEM_RD = 4'($urandom_range(15)); MEM_DATA = $urandom;
            end
            if (!ALU_VALID && $urandom_range(1) == 1) begin
                ALU_VALID = 1; ALU_RD = 4'($urandom_range(15)); ALU_DATA = $urandom;
            end
            ISSUE_VALID = ($urandom_range(3) == 0);
            ISSUE_RD    = 4'($urandom_range(15));
            FLUSH       = ($urandom_range(31) == 0);
            cyc();
            if (mem_acc_m) MEM_VALID = 0;
            if (alu_acc_m) ALU_VALID = 0;
        end
        drive_clear();
        repeat (4) cyc();

        // Asynchronous reset while a write is on the port.
        ALU_VALID = 1; ALU_RD = 4'd1; ALU_DATA = 32'hDEAD; cyc();
        drive_clear(); cyc();
        chk("t7_we_before_reset", WE3, 1);
        #2 nRST = 0;
        #1;
        chk("t7_we_async", WE3, 0);     chk("t7_wa_async", WA3, 0);
        chk("t7_wd_async", WD3, 0);     chk("t7_busy_async", BUSY, 0);
        chk("t7_err_async", SB_ERR, 0); chk("t7_pc_async", PC_LOAD, 0);
        model_reset();
        @(negedge CLK);
        nRST = 1;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
